// File: rtl/seg_decoder.sv
// Recovers the displayed 8-bit value from two 9-segment digit buses with
// a stability window against glitches and flags illegal segment patterns.
module seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 12000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       seg1,
    input  logic [8:0]       seg2,
    output logic [7:0]       value,
    output logic [1:0]       dp,
    output logic             valid,
    output logic             err,
    output logic             change,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned    TW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [TW-1:0]  CNT_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [17:0]    BLANK    = {9'h100, 9'h100};

    logic [17:0]      sync1_q, sync2_q;
    logic [17:0]      cand_q, commit_q;
    logic [TW-1:0]    cnt_q;

    logic [7:0]       value_q, value_d;
    logic [1:0]       dp_q, dp_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             change_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Returns {legal, nibble}; unknown codes decode to nibble 0.
    function automatic logic [4:0] decode_code(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= BLANK;
            sync2_q <= BLANK;
        end else begin
            sync1_q <= {seg1, seg2};
            sync2_q <= sync1_q;
        end
    end

    // A pair commits only after it has matched the candidate for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= BLANK;
            cnt_q    <= '0;
            commit_q <= BLANK;
        end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (cand_q != commit_q) begin
            commit_q <= cand_q;
        end
    end

    // Digit gi = 1 is the high digit (seg1), gi = 0 the low digit (seg2).
    logic [3:0] nib [2];
    logic [1:0] en;
    logic [1:0] legal;

    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        logic [8:0] dig;
        logic [4:0] dec;
        assign dig       = commit_q[gi*9 +: 9];
        assign dec       = decode_code(dig[6:0]);
        assign en[gi]    = ~dig[8];
        assign legal[gi] = dec[4];
        assign nib[gi]   = en[gi] ? dec[3:0] : 4'h0;
    end

    assign value_d = {nib[1], nib[0]};
    assign dp_d    = {commit_q[16], commit_q[7]};
    assign valid_d = &en & &legal;
    assign err_d   = |(en & ~legal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= '0;
            dp_q      <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            change_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            value_q  <= value_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            change_q <= ({value_d, valid_d, err_d} != {value_q, valid_q, err_q});
            if (err_d && !err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign value   = value_q;
    assign dp      = dp_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign change  = change_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: stimulus pushes expected commits,
// a monitor pops them on every change pulse and checks timing and contents.
module tb_seg_decoder;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] seg1 = 9'h100;
    logic [8:0] seg2 = 9'h100;
    logic [7:0] value;
    logic [1:0] dp;
    logic       valid;
    logic       err;
    logic       change;
    logic [7:0] err_cnt;

    seg_decoder #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg1    (seg1),
        .seg2    (seg2),
        .value   (value),
        .dp      (dp),
        .valid   (valid),
        .err     (err),
        .change  (change),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  v;
        logic [1:0]  d;
        logic        val;
        logic        e;
        logic [7:0]  cnt;
        logic [31:0] at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [17:0] m_commit = {9'h100, 9'h100};
    logic [9:0]  m_last   = '0;
    logic [7:0]  m_cnt    = '0;
    logic [17:0] cur      = {9'h100, 9'h100};

    function automatic void ref_decode(input logic [17:0] p, output logic [7:0] v,
                                       output logic [1:0] d, output logic val, output logic e);
        logic [3:0] n [2];
        logic [8:0] dig;
        val = 1'b1;
        e   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int idx;
            dig  = (k == 0) ? p[17:9] : p[8:0];
            n[k] = 4'h0;
            idx  = -1;
            if (dig[8]) begin
                val = 1'b0;
            end else begin
                for (int j = 0; j < 16; j++) if (dig[6:0] == SEG[j]) idx = j;
                if (idx < 0) begin
                    e   = 1'b1;
                    val = 1'b0;
                end else begin
                    n[k] = idx[3:0];
                end
            end
        end
        v = {n[0], n[1]};
        d = {p[16], p[7]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // A pair held for SC+1 sampling edges or more commits and shows SC+4 edges later.
    task automatic commit_model(input logic [17:0] p, input int hold);
        logic [7:0] v;
        logic [1:0] d;
        logic       val;
        logic       e;
        exp_t       x;
        if (hold >= SC + 1 && p != m_commit) begin
            m_commit = p;
            ref_decode(p, v, d, val, e);
            if ({v, val, e} != m_last) begin
                if (e && !m_last[0] && m_cnt != 8'hFF) m_cnt++;
                x.v = v; x.d = d; x.val = val; x.e = e; x.cnt = m_cnt;
                x.at = 32'(cyc + SC + 4);
                sb.push_back(x);
                m_last = {v, val, e};
            end
        end
    endtask

    task automatic apply(input logic [8:0] a, input logic [8:0] b, input int hold);
        seg1 = a;
        seg2 = b;
        cur  = {a, b};
        commit_model(cur, hold);
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_steady(input string tag);
        logic [7:0] v;
        logic [1:0] d;
        logic       val;
        logic       e;
        ref_decode(m_commit, v, d, val, e);
        check({tag, "_value"}, value, v);
        check({tag, "_dp"}, dp, d);
        check({tag, "_valid"}, valid, val);
        check({tag, "_err"}, err, e);
        check({tag, "_err_cnt"}, err_cnt, m_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, value, 8'h00);
        check({tag, "_dp"}, dp, 2'b00);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_change"}, change, 1'b0);
        check({tag, "_err_cnt"}, err_cnt, 8'h00);
    endtask

    function automatic logic [8:0] rand_digit();
        int r;
        logic dpb;
        r   = $urandom_range(0, 9);
        dpb = 1'($urandom);
        if (r < 6)      return {1'b0, dpb, SEG[$urandom_range(0, 15)]};
        else if (r < 8) return {1'b0, dpb, 7'($urandom)};
        else            return {1'b1, dpb, 7'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && int'(sb[0].at) < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_change actual=none required_at_cyc=%0d (cyc %0d)", sb[0].at, cyc);
                void'(sb.pop_front());
            end
            if (change) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change actual=1 required=0 value=%0h (cyc %0d)", value, cyc);
                end else begin
                    mon_x = sb.pop_front();
                    check("txn_cycle", cyc, mon_x.at);
                    check("txn_value", value, mon_x.v);
                    check("txn_dp", dp, mon_x.d);
                    check("txn_valid", valid, mon_x.val);
                    check("txn_err", err, mon_x.e);
                    check("txn_err_cnt", err_cnt, mon_x.cnt);
                    $display("txn cyc=%0d value=%02h dp=%0b valid=%0b err=%0b err_cnt=%0d",
                             cyc, value, dp, valid, err, err_cnt);
                end
            end
        end
    end

    initial begin
        logic [8:0] a;
        logic [8:0] b;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        apply(9'h100, 9'h100, 100);
        check_steady("blank");

        apply(9'h04F, 9'h07C, 20);
        check_steady("digits_3b");

        for (int i = 0; i < 17; i++) apply(9'h04F, (i % 2 == 0) ? 9'h006 : 9'h05B, 3);
        apply(9'h04F, 9'h05B, 20);
        check_steady("after_toggle");

        apply(9'h01F, 9'h05B, 20);
        check_steady("illegal");
        for (int i = 0; i < 600; i++) apply((i % 2 == 0) ? 9'h04F : 9'h01F, 9'h05B, SC + 1);
        apply(9'h01F, 9'h06D, 20);
        check_steady("saturated");

        apply(9'h106, 9'h0BF, 20);
        check_steady("disabled_dp");

        apply(9'h07F, 9'h06F, 20);
        seg1 = 9'h066;
        seg2 = 9'h05E;
        cur  = {9'h066, 9'h05E};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        sb.delete();
        m_commit = {9'h100, 9'h100};
        m_last   = '0;
        m_cnt    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        commit_model(cur, 20);
        repeat (20) @(negedge clk);
        check_steady("after_reset");

        for (int i = 0; i < 300; i++) begin
            do begin
                a = rand_digit();
                b = rand_digit();
            end while ({a, b} == cur);
            apply(a, b, $urandom_range(1, 12));
        end
        do begin
            a = rand_digit();
            b = rand_digit();
        end while ({a, b} == cur);
        apply(a, b, 20);
        check_steady("random_end");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_decoder.md
Name: seg_decoder

Overview:
- Receive-side counterpart of the 9-segment display encoder. Samples the two 9-bit segment buses (seg1 = high digit, seg2 = low digit) and recovers the displayed 8-bit value.
- Filters glitches with a stability window and flags illegal patterns.
- Used as an on-board readback/self-check monitor and as the bench scoreboard front end for the display path.
- Sits on the 12 MHz system clock beside the display driver.

Parameters:
- STABLE_CYCLES, 12000, clocks a sampled pattern pair must hold unchanged before it is committed (1 ms at 12 MHz). Legal range is 1 to 2^20.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  12 MHz system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- seg1  input  9  high-digit segment bus, asynchronous to clk
- seg2  input  9  low-digit segment bus, asynchronous to clk
- value  output  8  decoded value {digit1, digit2}
- dp  output  2  decimal-point bits {seg1[7], seg2[7]} of the committed pair
- valid  output  1  both digits enabled and legal
- err  output  1  at least one enabled digit carries an illegal pattern
- change  output  1  one-clock pulse when the committed decoded value or status changes
- err_cnt  output  CNT_W  saturating count of commits that entered the error state

Behaviour:
- Segment format, fixed:
  - bit8 = digit common, 0 = enabled.
  - bit7 = DP.
  - bits6:0 = g,f,e,d,c,b,a, active high.
- Legal codes on bits6:0 (hex digit: code):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Any other code on an enabled digit is illegal.
- A disabled digit (bit8 = 1) decodes to nibble 0, is not an error, and forces valid = 0.
- Synchronizer:
  - 2-flop synchronizer on all 18 bits (s).
  - Reset value of every synchronizer flop is 9'h100 per digit (blank).
- Stability filter:
  - Registers: cand (18 bits), cnt (ceil(log2(STABLE_CYCLES)) bits, min 1), committed (18 bits).
  - If s != cand: cand <= s, cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Else if cand != committed: committed <= cand.
  - With STABLE_CYCLES = 1, a pattern commits on the first clock after cand matches s.
- Decode stage, registered, one clock after committed updates:
  - value, dp, valid and err are computed from committed.
  - change = 1 for exactly one clock if {value, valid, err} differs from its previous registered value. A dp-only difference does not pulse change.
- err_cnt increments by 1 on the decode-stage clock where err goes 0 -> 1. It saturates at all-ones and never wraps.
- Latency: an input change that stays stable updates the outputs exactly STABLE_CYCLES+4 rising edges after the first edge that samples it. This is 2 sync + 1 cand load + (STABLE_CYCLES-1) count + 1 commit + 1 decode.
- Glitch rule: any input change shorter than STABLE_CYCLES+1 clocks of stable s leaves committed and all outputs untouched.
- A new change during counting restarts cnt from 0. There is no partial commit.
- Reset values:
  - value = 8'h00, dp = 2'b00, valid = 0, err = 0, change = 0, err_cnt = 0.
  - cand = committed = {9'h100, 9'h100}, cnt = 0.
- Reset mid-count discards the pending candidate. The first commit after release still obeys the full window.
- Re-committing an identical pair cannot occur: the cand != committed guard holds, so change never pulses on a steady input.

Test Plan:
- Reset, both inputs blank (9'h100) for 100 clocks -> value 00, valid 0, err 0, change never pulses, err_cnt 0.
- STABLE_CYCLES = 4; seg1 = 9'h04F, seg2 = 9'h07C -> exactly 8 clocks after first sample: value 8'h3B, valid 1, err 0, one change pulse.
- STABLE_CYCLES = 4; seg2 toggles 9'h006 / 9'h05B every 3 clocks for 50 clocks, then holds 9'h05B -> no output change during toggling; value low nibble = 2 exactly 8 clocks after the final transition.
- seg1 = 9'h01F (illegal) -> err 1, valid 0, err_cnt 1. Repeat illegal/legal alternation 300 times -> err_cnt saturates at 255.
- seg1 = 9'h106 (disabled), seg2 = 9'h0BF (DP set, digit 0) -> value 8'h00, valid 0, err 0, dp 2'b01.
- rst_n pulsed low while a new pattern is mid-window -> outputs return to reset values asynchronously. The pattern commits only after a full STABLE_CYCLES+4 clocks following release.
